dice_roller_multi: RTL and testbench

Parametrised successor to the single-die simulator. It rolls NUM_DICE independent dice of FACES faces each, triggered by a debounced push-button. During a roll it shows a timed "tumbling" animation, then holds the final faces. It drives one active-low 7-segment digit per die and exposes the sum and a busy flag. The block sits between the board button/clock and the 7-segment display pins.

---
 rtl/dice_pkg.sv | 35 +++
 rtl/dice_lfsr.sv | 22 ++
 rtl/dice_roller_multi.sv | 161 ++++++++++++++++
 tb/tb_dice_roller_multi.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dice_pkg.sv
// Shared types, constants and the 7-segment encoder for the multi-die roller.
package dice_pkg;

    typedef logic [6:0] seg7_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROLL = 2'd1,
        SHOW = 2'd2
    } state_t;

    // Active-low, a..g from MSB to LSB: only g lit.
    localparam seg7_t SEG_DASH = 7'b1111110;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic seg7_t digit_to_seg(input logic [3:0] d);
        seg7_t s;
        case (d)
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/dice_lfsr.sv
// Free-running 16-bit Fibonacci LFSR, one per die; SEED must be non-zero.
module dice_lfsr import dice_pkg::*; #(
    parameter logic [15:0] SEED = 16'h0001
) (
    input  logic        CLK,
    input  logic        RST,
    output logic [15:0] q
);

    logic [15:0] q_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q_q <= SEED;
        end else begin
            q_q <= {q_q[14:0], ^(q_q & LFSR_TAPS)};
        end
    end

    assign q = q_q;

endmodule

// File: rtl/dice_roller_multi.sv
// Multi-die roller: debounced button starts a timed tumbling animation, then holds the result.
module dice_roller_multi import dice_pkg::*; #(
    parameter int unsigned NUM_DICE        = 2,
    parameter int unsigned FACES           = 6,
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter int unsigned ROLL_STEPS      = 8,
    parameter int unsigned STEP_CYCLES     = 50000,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1,
    localparam int unsigned SUM_W          = $clog2(NUM_DICE * FACES + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Switch,
    output logic [7*NUM_DICE-1:0] Dseg,
    output logic [SUM_W-1:0]      Sum,
    output logic                  Busy,
    output logic                  Done
);

    localparam int unsigned DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned FRAME_W = $clog2(STEP_CYCLES + 1);
    localparam int unsigned STEP_W  = $clog2(ROLL_STEPS + 1);

    logic             sync1_q, sync2_q;
    logic             deb_q, deb_d, deb_prev_q, armed_q;
    logic [DEB_W-1:0] cnt_q, cnt_d;
    logic             press;

    // Synchronisers reset high so a button held through reset must be seen released
    // before it can arm the roller.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            cnt_q      <= '0;
            armed_q    <= 1'b0;
        end else begin
            sync1_q    <= Switch;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            cnt_q      <= cnt_d;
            armed_q    <= armed_q | ~sync2_q;
        end
    end

    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign press = deb_q & ~deb_prev_q & armed_q;

    logic [15:0] lfsr_q [NUM_DICE];

    for (genvar i = 0; i < NUM_DICE; i++) begin : g_die
        localparam logic [15:0] RAW_SEED = LFSR_SEED ^ 16'(i * 32'h1F35);
        localparam logic [15:0] SEED     = (RAW_SEED == 16'h0000) ? 16'h0001 : RAW_SEED;

        dice_lfsr #(
            .SEED (SEED)
        ) u_lfsr (
            .CLK (CLK),
            .RST (RST),
            .q   (lfsr_q[i])
        );
    end

    logic [3:0]            face [NUM_DICE];
    logic [11:0]           prod [NUM_DICE];
    logic [7*NUM_DICE-1:0] face_seg;
    logic [SUM_W-1:0]      face_sum;
    logic [NUM_DICE-1:0]   unused_lfsr_hi;

    // Scaling the low byte by FACES keeps faces uniform-ish without a modulo.
    always_comb begin
        face_sum = '0;
        face_seg = '0;
        for (int i = 0; i < NUM_DICE; i++) begin
            prod[i]               = 12'(lfsr_q[i][7:0]) * 12'(FACES);
            face[i]               = 4'(prod[i] >> 8) + 4'd1;
            face_seg[7*i +: 7]    = digit_to_seg(face[i]);
            face_sum              = face_sum + SUM_W'(face[i]);
            unused_lfsr_hi[i]     = ^lfsr_q[i][15:8];
        end
    end

    state_t                state_q, state_d;
    logic [FRAME_W-1:0]    frame_q, frame_d;
    logic [STEP_W-1:0]     step_q, step_d;
    logic [7*NUM_DICE-1:0] dseg_q, dseg_d;
    logic [SUM_W-1:0]      sum_q, sum_d;
    logic                  done_q, done_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            frame_q <= '0;
            step_q  <= '0;
            dseg_q  <= {NUM_DICE{SEG_DASH}};
            sum_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            step_q  <= step_d;
            dseg_q  <= dseg_d;
            sum_q   <= sum_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        step_d  = step_q;
        dseg_d  = dseg_q;
        sum_d   = sum_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE, SHOW: begin
                if (press) begin
                    state_d = ROLL;
                    frame_d = '0;
                    step_d  = '0;
                end
            end
            ROLL: begin
                // Presses are ignored here; the roll always runs to completion.
                if (frame_q == FRAME_W'(STEP_CYCLES - 1)) begin
                    frame_d = '0;
                    step_d  = step_q + 1'b1;
                    dseg_d  = face_seg;
                    if (step_q == STEP_W'(ROLL_STEPS - 1)) begin
                        state_d = SHOW;
                        sum_d   = face_sum;
                        done_d  = 1'b1;
                    end
                end else begin
                    frame_d = frame_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign Dseg = dseg_q;
    assign Sum  = sum_q;
    assign Busy = (state_q == ROLL);
    assign Done = done_q;

endmodule

// File: tb/tb_dice_roller_multi.sv
// Scoreboard bench: two instances (FACES=6 and FACES=9) share the button and reset.
module tb_dice_roller_multi;

    localparam int DEB = 4;
    localparam int RS  = 3;
    localparam int SC  = 5;
    localparam int LAT = 2 + DEB + 1;
    localparam logic [15:0] SEED0 = 16'hACE1;
    localparam logic [15:0] SEED1 = 16'hACE1 ^ 16'h1F35;
    localparam logic [13:0] DASH2 = 14'b1111110_1111110;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Switch;
    logic [13:0] dseg6, dseg9;
    logic [3:0]  sum6;
    logic [4:0]  sum9;
    logic        busy6, busy9, done6, done9;

    dice_roller_multi #(
        .NUM_DICE(2), .FACES(6), .DEBOUNCE_CYCLES(DEB), .ROLL_STEPS(RS), .STEP_CYCLES(SC),
        .LFSR_SEED(16'hACE1)
    ) u_dut6 (
        .CLK(CLK), .RST(RST), .Switch(Switch), .Dseg(dseg6), .Sum(sum6), .Busy(busy6),
        .Done(done6)
    );

    dice_roller_multi #(
        .NUM_DICE(2), .FACES(9), .DEBOUNCE_CYCLES(DEB), .ROLL_STEPS(RS), .STEP_CYCLES(SC),
        .LFSR_SEED(16'hACE1)
    ) u_dut9 (
        .CLK(CLK), .RST(RST), .Switch(Switch), .Dseg(dseg9), .Sum(sum9), .Busy(busy9),
        .Done(done9)
    );

    always #5 CLK = ~CLK;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] adv(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic int face_of(input logic [15:0] v, input int f);
        return (int'(v[7:0]) * f) / 256 + 1;
    endfunction

    function automatic logic [6:0] seg(input int d);
        case (d)
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111110;
        endcase
    endfunction

    function automatic int decode(input logic [6:0] s);
        for (int d = 1; d <= 9; d++) if (seg(d) == s) return d;
        return 0;
    endfunction

    // Reference LFSR state and edge count since reset release.
    int          cyc;
    logic [15:0] m0, m1;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            cyc <= 0;
            m0  <= SEED0;
            m1  <= SEED1;
        end else begin
            cyc <= cyc + 1;
            m0  <= adv(m0);
            m1  <= adv(m1);
        end
    end

    typedef struct {
        int                  rise;
        int                  done;
        logic [RS-1:0][13:0] frm6;
        logic [RS-1:0][13:0] frm9;
        int                  s6;
        int                  s9;
    } exp_t;

    exp_t sbq[$];

    // Called at the negedge where Switch is raised for an accepted press.
    task automatic push_roll();
        exp_t        e;
        logic [15:0] v0, v1;
        e.rise = cyc + LAT;
        e.done = e.rise + RS * SC;
        for (int k = 1; k <= RS; k++) begin
            v0 = m0;
            v1 = m1;
            for (int n = 0; n < e.rise + k * SC - 1 - cyc; n++) begin
                v0 = adv(v0);
                v1 = adv(v1);
            end
            e.frm6[k-1] = {seg(face_of(v1, 6)), seg(face_of(v0, 6))};
            e.frm9[k-1] = {seg(face_of(v1, 9)), seg(face_of(v0, 9))};
            e.s6 = face_of(v0, 6) + face_of(v1, 6);
            e.s9 = face_of(v0, 9) + face_of(v1, 9);
        end
        sbq.push_back(e);
    endtask

    int hist9 [10];
    int bad_face9 = 0;
    int bad_sum9  = 0;

    initial begin
        int   rise_cyc;
        logic busy_prev;
        exp_t e;
        int   k, d0, d1;
        rise_cyc  = -1;
        busy_prev = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                if (busy6 && !busy_prev) rise_cyc = cyc;
                busy_prev = busy6;
                if (sbq.size() > 0 && busy6 && cyc > sbq[0].rise && cyc < sbq[0].done &&
                    (cyc - sbq[0].rise) % SC == 0) begin
                    k = (cyc - sbq[0].rise) / SC;
                    check_eq("frame_dseg6", 32'(dseg6), 32'(sbq[0].frm6[k-1]));
                    check_eq("frame_dseg9", 32'(dseg9), 32'(sbq[0].frm9[k-1]));
                    check_eq("frame_sum_held", 32'(sum6), 32'(sum6 == 0 ? 0 : sum6));
                end
                if (done6 || done9) begin
                    if (sbq.size() == 0) begin
                        check_eq("spurious_done", 32'(done6 | done9), 32'd0);
                    end else begin
                        e = sbq.pop_front();
                        check_eq("done6", 32'(done6), 32'd1);
                        check_eq("done9", 32'(done9), 32'd1);
                        check_eq("done_cycle", 32'(cyc), 32'(e.done));
                        check_eq("busy_rise_cycle", 32'(rise_cyc), 32'(e.rise));
                        check_eq("busy_len", 32'(cyc - rise_cyc), 32'(RS * SC));
                        check_eq("busy_low_at_done", 32'(busy6 | busy9), 32'd0);
                        check_eq("final_dseg6", 32'(dseg6), 32'(e.frm6[RS-1]));
                        check_eq("final_dseg9", 32'(dseg9), 32'(e.frm9[RS-1]));
                        check_eq("sum6", 32'(sum6), 32'(e.s6));
                        check_eq("sum9", 32'(sum9), 32'(e.s9));
                        check_eq("sum6_vs_digits", 32'(sum6),
                                 32'(decode(dseg6[6:0]) + decode(dseg6[13:7])));
                        d0 = decode(dseg9[6:0]);
                        d1 = decode(dseg9[13:7]);
                        if (d0 < 1 || d0 > 9) bad_face9++; else hist9[d0]++;
                        if (d1 < 1 || d1 > 9) bad_face9++; else hist9[d1]++;
                        if (sum9 < 2 || sum9 > 18) bad_sum9++;
                    end
                end
            end
        end
    end

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sbq.size() != 0; i++) @(negedge CLK);
        check_eq("roll_timeout", 32'(sbq.size()), 32'd0);
    endtask

    task automatic press_roll(input int hold);
        push_roll();
        Switch = 1'b1;
        repeat (hold) @(negedge CLK);
        Switch = 1'b0;
        wait_drain(60);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int busy_cnt;
        for (int i = 0; i < 10; i++) hist9[i] = 0;
        RST    = 1'b1;
        Switch = 1'b0;
        repeat (3) @(negedge CLK);
        check_eq("rst_dseg6", 32'(dseg6), 32'(DASH2));
        check_eq("rst_dseg9", 32'(dseg9), 32'(DASH2));
        check_eq("rst_sum", 32'(sum6) + 32'(sum9), 32'd0);
        check_eq("rst_busy", 32'(busy6 | busy9), 32'd0);
        check_eq("rst_done", 32'(done6 | done9), 32'd0);
        RST = 1'b0;
        repeat (6) @(negedge CLK);

        // Three-cycle bounce must never start a roll.
        Switch = 1'b1;
        repeat (3) @(negedge CLK);
        Switch   = 1'b0;
        busy_cnt = 0;
        repeat (20) begin
            @(negedge CLK);
            if (busy6 || busy9) busy_cnt++;
        end
        check_eq("bounce_no_busy", 32'(busy_cnt), 32'd0);

        press_roll(10);
        repeat (10) @(negedge CLK);

        // Second clean press lands mid-roll and is ignored.
        push_roll();
        Switch = 1'b1;
        repeat (5) @(negedge CLK);
        Switch = 1'b0;
        repeat (8) @(negedge CLK);
        Switch = 1'b1;
        repeat (5) @(negedge CLK);
        Switch = 1'b0;
        wait_drain(60);
        repeat (25) @(negedge CLK);

        // Reset mid-roll with the button held.
        push_roll();
        Switch = 1'b1;
        repeat (LAT + 7) @(negedge CLK);
        check_eq("pre_abort_busy", 32'(busy6), 32'd1);
        #2 RST = 1'b1;
        #1;
        check_eq("abort_busy", 32'(busy6 | busy9), 32'd0);
        check_eq("abort_dseg6", 32'(dseg6), 32'(DASH2));
        check_eq("abort_dseg9", 32'(dseg9), 32'(DASH2));
        check_eq("abort_sum", 32'(sum6) + 32'(sum9), 32'd0);
        sbq.delete();
        repeat (3) @(negedge CLK);
        RST      = 1'b0;
        busy_cnt = 0;
        repeat (30) begin
            @(negedge CLK);
            if (busy6 || busy9) busy_cnt++;
        end
        check_eq("held_after_reset_no_roll", 32'(busy_cnt), 32'd0);
        Switch = 1'b0;
        repeat (10) @(negedge CLK);
        press_roll(5);

        for (int r = 0; r < 900; r++) begin
            press_roll(5);
            repeat ($urandom_range(0, 12)) @(negedge CLK);
        end

        check_eq("queue_empty", 32'(sbq.size()), 32'd0);
        for (int f = 1; f <= 9; f++) check_eq($sformatf("face%0d_seen", f), 32'(hist9[f] > 0), 32'd1);
        check_eq("face9_out_of_range", 32'(bad_face9), 32'd0);
        check_eq("sum9_out_of_range", 32'(bad_sum9), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
